// File: rtl/mux_rr_arbiter_2bit.sv
// mux_rr_arbiter_2bit: round-robin arbiter with hold-limit preemption steering a 4x1 2-bit data mux
module mux_rr_arbiter_2bit #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [1:0] din_a,
    input  logic [1:0] din_b,
    input  logic [1:0] din_c,
    input  logic [1:0] din_d,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic [1:0] dout,
    output logic       valid
);
    typedef enum logic {IDLE, OWN} state_t;
    localparam logic [3:0] MAXH = 4'(MAX_HOLD);
    state_t     state;
    logic [1:0] ptr;
    logic [1:0] win;
    logic [3:0] hcnt;
    logic       others;
    // first asserted request scanning upward from ptr; later iterations overwrite, so lowest offset wins
    always_comb begin
        win = ptr;
        for (int i = 3; i >= 0; i--) if (req[ptr + 2'(i)]) win = ptr + 2'(i);
    end
    assign others = |(req & ~grant);
    // arbitration state: grant on IDLE, release on owner drop or hold-limit preemption
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            ptr   <= '0;
            hcnt  <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                state <= OWN;
                grant <= 4'b0001 << win;
                sel   <= win;
                hcnt  <= 4'd1;
                ptr   <= win + 2'd1;
            end
        end else if (!req[sel] || (hcnt == MAXH && others)) begin
            state <= IDLE;
            grant <= '0;
        end else if (hcnt != MAXH) begin
            hcnt <= hcnt + 4'd1;
        end
    end
    assign valid = |grant;
    assign dout  = !valid      ? 2'b00 :
                   sel == 2'd0 ? din_a :
                   sel == 2'd1 ? din_b :
                   sel == 2'd2 ? din_c : din_d;
endmodule

// File: tb/tb_mux_rr_arbiter_2bit.sv
// tb_mux_rr_arbiter_2bit: directed vector table plus hand sequences for preemption, rotation, saturation and reset
module tb_mux_rr_arbiter_2bit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [1:0] din_a = 2'b00, din_b = 2'b00, din_c = 2'b00, din_d = 2'b00;
    logic [3:0] grant, grant2;
    logic [1:0] sel, sel2, dout, dout2;
    logic       valid, valid2;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter_2bit #(.MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .req(req),
        .din_a(din_a), .din_b(din_b), .din_c(din_c), .din_d(din_d),
        .grant(grant), .sel(sel), .dout(dout), .valid(valid)
    );

    mux_rr_arbiter_2bit #(.MAX_HOLD(2)) dut2 (
        .clk(clk), .rst(rst), .req(req),
        .din_a(din_a), .din_b(din_b), .din_c(din_c), .din_d(din_d),
        .grant(grant2), .sel(sel2), .dout(dout2), .valid(valid2)
    );

    typedef struct {
        logic       r;
        logic [3:0] q;
        logic [1:0] a, b, c, d;
        logic [3:0] g;
        logic [1:0] s;
        logic [1:0] o;
        logic       v;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'b1111, 2'b01, 2'b10, 2'b01, 2'b10, 4'b0000, 2'd0, 2'b00, 1'b0};
        tbl[1]  = '{1'b0, 4'b0100, 2'b00, 2'b11, 2'b10, 2'b01, 4'b0100, 2'd2, 2'b10, 1'b1};
        tbl[2]  = '{1'b0, 4'b0000, 2'b01, 2'b10, 2'b10, 2'b01, 4'b0000, 2'd2, 2'b00, 1'b0};
        tbl[3]  = '{1'b0, 4'b0000, 2'b10, 2'b01, 2'b11, 2'b10, 4'b0000, 2'd2, 2'b00, 1'b0};
        tbl[4]  = '{1'b0, 4'b0011, 2'b01, 2'b10, 2'b11, 2'b10, 4'b0001, 2'd0, 2'b01, 1'b1};
        tbl[5]  = '{1'b0, 4'b0000, 2'b01, 2'b10, 2'b11, 2'b10, 4'b0000, 2'd0, 2'b00, 1'b0};
        tbl[6]  = '{1'b0, 4'b0011, 2'b01, 2'b10, 2'b01, 2'b01, 4'b0010, 2'd1, 2'b10, 1'b1};
        tbl[7]  = '{1'b0, 4'b1010, 2'b10, 2'b01, 2'b10, 2'b10, 4'b0010, 2'd1, 2'b01, 1'b1};
        tbl[8]  = '{1'b0, 4'b1000, 2'b10, 2'b01, 2'b10, 2'b10, 4'b0000, 2'd1, 2'b00, 1'b0};
        tbl[9]  = '{1'b0, 4'b1000, 2'b10, 2'b10, 2'b10, 2'b01, 4'b1000, 2'd3, 2'b01, 1'b1};
        tbl[10] = '{1'b0, 4'b1000, 2'b10, 2'b10, 2'b10, 2'b10, 4'b1000, 2'd3, 2'b10, 1'b1};
        tbl[11] = '{1'b0, 4'b0000, 2'b11, 2'b11, 2'b11, 2'b11, 4'b0000, 2'd3, 2'b00, 1'b0};

        #2;
        foreach (tbl[i]) begin
            rst = tbl[i].r;
            req = tbl[i].q;
            din_a = tbl[i].a;
            din_b = tbl[i].b;
            din_c = tbl[i].c;
            din_d = tbl[i].d;
            step();
            chk($sformatf("vec%0d grant", i), int'(grant), int'(tbl[i].g));
            chk($sformatf("vec%0d sel", i), int'(sel), int'(tbl[i].s));
            chk($sformatf("vec%0d dout", i), int'(dout), int'(tbl[i].o));
            chk($sformatf("vec%0d valid", i), int'(valid), int'(tbl[i].v));
        end

        // preemption: A holds 8 cycles while B waits, one idle cycle, then B
        do_reset();
        req = 4'b0001;
        step();
        chk("pre first grant", int'(grant), 4'b0001);
        req = 4'b0011;
        for (int k = 2; k <= 8; k++) begin
            step();
            chk($sformatf("pre hold cyc%0d", k), int'(grant), 4'b0001);
        end
        step();
        chk("pre release gap", int'(grant), 4'b0000);
        step();
        chk("pre next owner", int'(grant), 4'b0010);
        chk("pre next sel", int'(sel), 1);

        // rotation on the MAX_HOLD=2 instance: two owned cycles then a gap per requester
        begin
            logic [3:0] rr_exp [14];
            rr_exp = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                       4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001};
            do_reset();
            req = 4'b1111;
            foreach (rr_exp[k]) begin
                step();
                chk($sformatf("rr cyc%0d", k), int'(grant2), int'(rr_exp[k]));
            end
        end

        // saturation with no competitor: D keeps the grant, counter pinned at MAX_HOLD
        do_reset();
        req = 4'b1000;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("sat cyc%0d", k), int'(grant), 4'b1000);
        end
        chk("sat hcnt", int'(dut.hcnt), 8);

        // reset mid-ownership restarts arbitration from A
        do_reset();
        req = 4'b0100;
        step();
        chk("rstmid C owns", int'(grant), 4'b0100);
        req = 4'b1111;
        rst = 1'b1;
        step();
        chk("rstmid grant", int'(grant), 4'b0000);
        chk("rstmid sel", int'(sel), 0);
        chk("rstmid valid", int'(valid), 0);
        rst = 1'b0;
        step();
        chk("rstmid after", int'(grant), 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_rr_arbiter_2bit.md
MUX_RR_ARBITER_2BIT -- requirements
Module: mux_rr_arbiter_2bit

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum owned cycles before preemption when others wait (legal range 2..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  4  request per requester; bit i = requester i (A=0, B=1, C=2, D=3).
REQ-005 din_a, din_b, din_c, din_d  input  2 each  requester data; bit 1 maps to mux input x1, bit 0 to x0.
REQ-006 grant  output  4  registered one-hot grant; all zero when no owner.
REQ-007 sel  output  2  registered mux select {S1,S0} = owner index; holds last value when no owner.
REQ-008 dout  output  2  granted data {Out1,Out2}, combinational from sel and din_*; 2'b00 when grant is zero.
REQ-009 valid  output  1  high when grant nonzero.

Function
REQ-010 The block SHALL implement two states, IDLE and OWN, plus a 2-bit round-robin pointer ptr and a 4-bit hold counter hcnt.
REQ-011 In IDLE with req nonzero, the block SHALL pick the winner as the first asserted req index scanning ptr, ptr+1, ... mod 4, then enter OWN at the next edge.
REQ-012 On entering OWN, the block SHALL set grant to one-hot(winner), sel to winner, hcnt to 1, and ptr to (winner+1) mod 4.
REQ-013 Latency: req sampled high in IDLE at edge N SHALL produce grant/valid high after edge N+1 (one cycle).
REQ-014 In IDLE with req zero, state, grant, sel, ptr, and hcnt SHALL hold.
REQ-015 In OWN, when req[owner] is sampled low, the block SHALL return to IDLE with grant cleared at the next edge (normal release).
REQ-016 After any release, grant SHALL be zero for exactly one cycle (IDLE gap) before the next grant.
REQ-017 In OWN with req[owner] high, hcnt SHALL increment each cycle and saturate at MAX_HOLD.
REQ-018 In OWN, when hcnt == MAX_HOLD and any other req bit is high, the block SHALL force release to IDLE at the next edge (preemption).
REQ-019 When hcnt == MAX_HOLD and no other req bit is high, the owner SHALL keep the grant indefinitely.
REQ-020 When normal release and preemption coincide, the block SHALL treat the event as a normal release, with identical resulting state.
REQ-021 A new req rising in OWN SHALL NOT change grant until the owner releases or is preempted.
REQ-022 dout SHALL equal din_a/b/c/d selected by sel per the 4x1 mux truth table (00->A, 01->B, 10->C, 11->D) whenever valid is high.
REQ-023 grant SHALL never have more than one bit set.

Reset
REQ-024 With rst high at an edge, the block SHALL set state=IDLE, grant=0000, sel=00, ptr=0, hcnt=0, valid=0, dout=00, regardless of state or req.
REQ-025 rst SHALL take priority over every other transition, including mid-ownership; the first arbitration after reset starts from ptr=0.

Verification
REQ-026 The bench SHALL cover single request: after reset, req=0100 -> after 1 edge grant=0100, sel=10, dout=din_c; drop req -> next edge grant=0000.
REQ-027 The bench SHALL cover round robin: req=1111 held with MAX_HOLD=2 -> owners A,B,C,D,A in order; each tenure 2 cycles followed by a 1-cycle zero gap.
REQ-028 The bench SHALL cover preemption: A owns with req=0001, then req=0011 with MAX_HOLD=8 -> A released after its 8th owned cycle, gap, then grant=0010.
REQ-029 The bench SHALL cover no-preempt saturation: req=1000 held for 20 cycles -> grant=1000 throughout, hcnt stays at 8.
REQ-030 The bench SHALL cover reset mid-operation: C owns, rst pulsed 1 cycle with req=1111 -> grant=0000 during reset cycle, then grant=0001 (ptr reset to 0).
REQ-031 The bench SHALL cover data path: every sel value with din patterns 01/10 -> dout matches the selected input, and dout=00 while valid=0.
